// File: rtl/wave_key_ctrl_pkg.sv
// wave_key_pkg: waveform select codes, debounce FSM states and the priority pick helper
package wave_key_pkg;
    localparam logic [3:0] WAVE_NONE     = 4'b0000;
    localparam logic [3:0] WAVE_SINE     = 4'b0001;
    localparam logic [3:0] WAVE_SQUARE   = 4'b0010;
    localparam logic [3:0] WAVE_TRIANGLE = 4'b0100;
    localparam logic [3:0] WAVE_SAWTOOTH = 4'b1000;

    typedef enum logic [1:0] {IDLE, PRESS_F, PRESSED, REL_F} deb_state_t;

    // Isolates the lowest set bit, so key0 wins when presses coincide
    function automatic logic [3:0] lowest_onehot(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction
endpackage

// File: rtl/wave_key_ctrl_if.sv
// wave_key_ctrl_if: raw key inputs and the waveform select / accept pulse towards dds_ctrl
interface wave_key_ctrl_if;
    logic [3:0] key_n;
    logic [3:0] wave_sel;
    logic       key_flag;
    modport master (output key_n, input wave_sel, key_flag);
    modport slave  (input key_n, output wave_sel, key_flag);
endinterface

// File: rtl/wave_key_ctrl_debounce.sv
// key_debounce: 2-FF synchronizer plus press/release debounce FSM for one active-low key
module key_debounce
    import wave_key_pkg::*;
#(
    parameter int CNT_MAX = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press_ok
);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CLAST = CW'(CNT_MAX - 1);

    logic [1:0]    r_sync;
    deb_state_t    r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          w_key_s;

    assign w_key_s = r_sync[1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync  <= 2'b11;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], key_n};
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // press_ok is Mealy so the top can register the select on the accepting edge itself
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        press_ok   = 1'b0;
        unique case (r_state)
            IDLE: if (!w_key_s) begin
                w_state_nx = PRESS_F;
                w_cnt_nx   = '0;
            end
            PRESS_F: if (w_key_s) begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end else if (r_cnt == CLAST) begin
                w_state_nx = PRESSED;
                w_cnt_nx   = '0;
                press_ok   = 1'b1;
            end else w_cnt_nx = r_cnt + 1'b1;
            PRESSED: if (w_key_s) begin
                w_state_nx = REL_F;
                w_cnt_nx   = '0;
            end
            REL_F: if (!w_key_s) begin
                w_state_nx = PRESSED;
                w_cnt_nx   = '0;
            end else if (r_cnt == CLAST) begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end else w_cnt_nx = r_cnt + 1'b1;
        endcase
    end
endmodule

// File: rtl/wave_key_ctrl.sv
// wave_key_ctrl: four debounced keys -> registered one-hot waveform select for dds_ctrl.
// Define WAVE_DEMO_EN to build the auto-rotating demo that runs until the first accepted press.
module wave_key_ctrl
    import wave_key_pkg::*;
#(
    parameter int CNT_MAX  = 1_000_000,
    parameter int DEMO_CNT = 50_000_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    wave_key_ctrl_if.slave  bus
);
    logic [3:0] w_press;
    logic [3:0] w_pick;
    logic [3:0] r_wave_sel;
    logic       r_key_flag;

    if (CNT_MAX < 2 || DEMO_CNT < 2) begin : g_bad_param
        $error("wave_key_ctrl: CNT_MAX and DEMO_CNT must be at least 2");
    end

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.CNT_MAX(CNT_MAX)) u_deb (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_n     (bus.key_n[i]),
            .press_ok  (w_press[i])
        );
    end

    assign w_pick = lowest_onehot(w_press);

`ifdef WAVE_DEMO_EN
    localparam int DW = $clog2(DEMO_CNT);

    logic [DW-1:0] r_demo_cnt;
    logic          r_demo_on;
    logic          w_wrap;
    logic [3:0]    w_rot;

    assign w_wrap = r_demo_cnt == DW'(DEMO_CNT - 1);
    assign w_rot  = (r_wave_sel[3] || r_wave_sel == WAVE_NONE) ? WAVE_SINE : {r_wave_sel[2:0], 1'b0};

    // A press on the same edge as a wrap takes priority and ends the demo for good
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_demo_cnt <= '0;
            r_demo_on  <= 1'b1;
            r_wave_sel <= WAVE_NONE;
            r_key_flag <= 1'b0;
        end else begin
            r_key_flag <= |w_press;
            if (r_demo_on) r_demo_cnt <= w_wrap ? '0 : r_demo_cnt + 1'b1;
            if (|w_press) begin
                r_wave_sel <= w_pick;
                r_demo_on  <= 1'b0;
            end else if (r_demo_on && w_wrap) r_wave_sel <= w_rot;
        end
    end
`else
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wave_sel <= WAVE_NONE;
            r_key_flag <= 1'b0;
        end else begin
            r_key_flag <= |w_press;
            if (|w_press) r_wave_sel <= w_pick;
        end
    end
`endif

    assign bus.wave_sel = r_wave_sel;
    assign bus.key_flag = r_key_flag;
endmodule

// File: tb/tb_wave_key_ctrl.sv
// tb_wave_key_ctrl: directed bench for wave_key_ctrl with CNT_MAX=20, DEMO_CNT=100, 50 MHz clock.
module tb_wave_key_ctrl;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   flag_cnt = 0;

    wave_key_ctrl_if bus();

    wave_key_ctrl #(.CNT_MAX(20), .DEMO_CNT(100)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #10 sys_clk = ~sys_clk;

    // Advance n edges, sampling 1 ns after each one and tallying key_flag pulses
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            if (bus.key_flag === 1'b1) flag_cnt++;
        end
    endtask

    task automatic test_reset;
        bus.key_n = 4'hF;
        sys_rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.wave_sel !== 4'b0000 || bus.key_flag !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d got sel=%b flag=%b want sel=0000 flag=0", i, bus.wave_sel, bus.key_flag);
            end
        end
        sys_rst_n = 1'b1;
        step(5);
        checks++;
        if (bus.wave_sel !== 4'b0000 || bus.key_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got sel=%b flag=%b want sel=0000 flag=0", bus.wave_sel, bus.key_flag);
        end
    endtask

    task automatic test_clean_press;
        flag_cnt = 0;
        bus.key_n = 4'b1110;
        step(22);
        checks++;
        if (bus.wave_sel !== 4'b0000 || flag_cnt !== 0) begin
            errors++;
            $display("FAIL clean_early got sel=%b flags=%0d want sel=0000 flags=0", bus.wave_sel, flag_cnt);
        end
        step();
        checks++;
        if (bus.wave_sel !== 4'b0001 || bus.key_flag !== 1'b1) begin
            errors++;
            $display("FAIL clean_accept got sel=%b flag=%b want sel=0001 flag=1", bus.wave_sel, bus.key_flag);
        end
        step();
        checks++;
        if (bus.key_flag !== 1'b0) begin
            errors++;
            $display("FAIL clean_pulse_width got flag=%b want 0", bus.key_flag);
        end
        step(16);
        bus.key_n = 4'hF;
        step(40);
        checks++;
        if (bus.wave_sel !== 4'b0001 || flag_cnt !== 1) begin
            errors++;
            $display("FAIL clean_release got sel=%b flags=%0d want sel=0001 flags=1", bus.wave_sel, flag_cnt);
        end
    endtask

    task automatic test_bounce;
        flag_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            bus.key_n = 4'b1011;
            step(5);
            bus.key_n = 4'hF;
            step(3);
            checks++;
            if (bus.wave_sel !== 4'b0001 || flag_cnt !== 0) begin
                errors++;
                $display("FAIL bounce_hold burst %0d got sel=%b flags=%0d want sel=0001 flags=0", i, bus.wave_sel, flag_cnt);
            end
        end
        bus.key_n = 4'b1011;
        step(22);
        checks++;
        if (bus.wave_sel !== 4'b0001) begin
            errors++;
            $display("FAIL bounce_early got sel=%b want 0001", bus.wave_sel);
        end
        step();
        checks++;
        if (bus.wave_sel !== 4'b0100 || bus.key_flag !== 1'b1) begin
            errors++;
            $display("FAIL bounce_accept got sel=%b flag=%b want sel=0100 flag=1", bus.wave_sel, bus.key_flag);
        end
        bus.key_n = 4'hF;
        step(40);
        checks++;
        if (flag_cnt !== 1) begin
            errors++;
            $display("FAIL bounce_flags got %0d want 1", flag_cnt);
        end
    endtask

    task automatic test_simultaneous;
        flag_cnt = 0;
        bus.key_n = 4'b1010;
        step(23);
        checks++;
        if (bus.wave_sel !== 4'b0001 || bus.key_flag !== 1'b1) begin
            errors++;
            $display("FAIL simul_priority got sel=%b flag=%b want sel=0001 flag=1", bus.wave_sel, bus.key_flag);
        end
        step(20);
        bus.key_n = 4'hF;
        step(40);
        checks++;
        if (flag_cnt !== 1) begin
            errors++;
            $display("FAIL simul_flags got %0d want 1", flag_cnt);
        end
        bus.key_n = 4'b0111;
        step(23);
        checks++;
        if (bus.wave_sel !== 4'b1000) begin
            errors++;
            $display("FAIL simul_key3 got sel=%b want 1000", bus.wave_sel);
        end
        bus.key_n = 4'hF;
        step(40);
    endtask

    task automatic test_repress;
        flag_cnt = 0;
        bus.key_n = 4'b0111;
        step(22);
        checks++;
        if (flag_cnt !== 0) begin
            errors++;
            $display("FAIL repress_early got flags=%0d want 0", flag_cnt);
        end
        step();
        checks++;
        if (bus.wave_sel !== 4'b1000 || bus.key_flag !== 1'b1) begin
            errors++;
            $display("FAIL repress_accept got sel=%b flag=%b want sel=1000 flag=1", bus.wave_sel, bus.key_flag);
        end
        bus.key_n = 4'hF;
        step(40);
        checks++;
        if (flag_cnt !== 1) begin
            errors++;
            $display("FAIL repress_flags got %0d want 1", flag_cnt);
        end
    endtask

    task automatic test_reset_mid;
        flag_cnt = 0;
        bus.key_n = 4'b1101;
        step(10);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.wave_sel !== 4'b0000 || bus.key_flag !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got sel=%b flag=%b want sel=0000 flag=0", bus.wave_sel, bus.key_flag);
        end
        step(3);
        sys_rst_n = 1'b1;
        step(22);
        checks++;
        if (bus.wave_sel !== 4'b0000 || flag_cnt !== 0) begin
            errors++;
            $display("FAIL midreset_early got sel=%b flags=%0d want sel=0000 flags=0", bus.wave_sel, flag_cnt);
        end
        step();
        checks++;
        if (bus.wave_sel !== 4'b0010 || bus.key_flag !== 1'b1) begin
            errors++;
            $display("FAIL midreset_accept got sel=%b flag=%b want sel=0010 flag=1", bus.wave_sel, bus.key_flag);
        end
        bus.key_n = 4'hF;
        step(40);
    endtask

`ifdef WAVE_DEMO_EN
    task automatic test_demo;
        logic [3:0] exp_seq [5];
        logic [3:0] prev;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev = 4'b0000;
        bus.key_n = 4'hF;
        sys_rst_n = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
        flag_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step(99);
            checks++;
            if (bus.wave_sel !== prev) begin
                errors++;
                $display("FAIL demo_before_wrap %0d got sel=%b want %b", k, bus.wave_sel, prev);
            end
            step();
            checks++;
            if (bus.wave_sel !== exp_seq[k]) begin
                errors++;
                $display("FAIL demo_wrap %0d got sel=%b want %b", k, bus.wave_sel, exp_seq[k]);
            end
            prev = exp_seq[k];
        end
        checks++;
        if (flag_cnt !== 0) begin
            errors++;
            $display("FAIL demo_no_flag got flags=%0d want 0", flag_cnt);
        end
        bus.key_n = 4'b1011;
        step(23);
        checks++;
        if (bus.wave_sel !== 4'b0100 || bus.key_flag !== 1'b1) begin
            errors++;
            $display("FAIL demo_press got sel=%b flag=%b want sel=0100 flag=1", bus.wave_sel, bus.key_flag);
        end
        bus.key_n = 4'hF;
        step(250);
        checks++;
        if (bus.wave_sel !== 4'b0100) begin
            errors++;
            $display("FAIL demo_stopped got sel=%b want 0100", bus.wave_sel);
        end
    endtask
`endif

    initial begin
        bus.key_n = 4'hF;
        test_reset();
`ifdef WAVE_DEMO_EN
        test_demo();
`else
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_repress();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
